tc_program_loader: RTL and testbench

- Byte-stream loader that fills the 8-bit-addressed program memory read by the TC program ROM blocks.
- Accepts framed bytes over a valid/ready stream: sync, start address, length, payload, checksum.
- Emits one registered write per payload byte.
- Flags frame completion or checksum error, so a host or testbench can load programs at run time instead of via $readmemh.

---
 rtl/tc_loader_pkg.sv | 21 ++
 rtl/tc_loader_csum.sv | 26 ++
 rtl/tc_program_loader.sv | 140 ++++++++++++++
 tb/tb_tc_program_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_loader_pkg.sv
// Shared types and constants for the TC program loader.
// Frame format: sync, start address, length, payload bytes, checksum.
package tc_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_REPORT
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // A length byte of zero encodes a full 256-byte payload.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/tc_loader_csum.sv
// 8-bit running-sum accumulator for the loader frame checksum.
// sum_zero reports whether adding the current byte would bring the sum to zero.
module tc_loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       add,
    input  logic [7:0] data,
    output logic       sum_zero
);

    logic [7:0] sum_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg <= 8'd0;
        end else if (load) begin
            sum_reg <= data;
        end else if (add) begin
            sum_reg <= sum_reg + data;
        end
    end

    assign sum_zero = ((sum_reg + data) == 8'd0);

endmodule

// File: rtl/tc_program_loader.sv
// Framed byte-stream loader for the 8-bit-addressed TC program memory.
// Writes each payload byte one cycle after acceptance and reports checksum status.
module tc_program_loader
    import tc_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  abort,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [8:0]            last_count
);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic [8:0]            remaining_reg;
    logic [8:0]            len_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [7:0]            mem_wdata_reg;
    logic                  done_reg, err_reg;
    logic [8:0]            last_count_reg;

    logic accept;
    logic csum_load, csum_add, wr_next;
    logic sum_zero;

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready = (state_reg != ST_REPORT);
    assign accept   = in_valid & in_ready;

    tc_loader_csum u_csum (
        .clk      (clk),
        .rst      (rst),
        .load     (csum_load),
        .add      (csum_add),
        .data     (in_data),
        .sum_zero (sum_zero)
    );

    always_comb begin
        state_next = state_reg;
        csum_load  = 1'b0;
        csum_add   = 1'b0;
        wr_next    = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) state_next = ST_ADDR;
                end
                ST_ADDR: begin
                    if (accept) begin
                        csum_load  = 1'b1;
                        state_next = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        csum_add   = 1'b1;
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum_add = 1'b1;
                        wr_next  = 1'b1;
                        if (remaining_reg == 9'd1) state_next = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (accept) state_next = ST_REPORT;
                end
                ST_REPORT: state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            remaining_reg  <= 9'd0;
            len_reg        <= 9'd0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= 8'd0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            last_count_reg <= 9'd0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= wr_next;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            if (wr_next) begin
                mem_addr_reg  <= ptr_reg;
                mem_wdata_reg <= in_data;
                ptr_reg       <= ptr_reg + ADDR_WIDTH'(1);
                remaining_reg <= remaining_reg - 9'd1;
            end
            if (accept && !abort) begin
                case (state_reg)
                    ST_ADDR: ptr_reg <= ADDR_WIDTH'(in_data);
                    ST_LEN: begin
                        remaining_reg <= frame_len(in_data);
                        len_reg       <= frame_len(in_data);
                    end
                    ST_CSUM: begin
                        done_reg       <= sum_zero;
                        err_reg        <= ~sum_zero;
                        last_count_reg <= len_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign last_count = last_count_reg;

endmodule

// File: tb/tb_tc_program_loader.sv
// Directed bench for tc_program_loader: framing, checksum, wrap, stalls, abort, reset.
module tb_tc_program_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] last_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        logic       dn;
        logic       er;
        logic       rdy;
        logic       bsy;
    } obs_t;

    tc_program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .abort      (abort),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .last_count (last_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns outputs sampled at the negedge after acceptance.
    task automatic send(input logic [7:0] b, output obs_t o);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        o = '{we: mem_we, a: mem_addr, d: mem_wdata, dn: done, er: err, rdy: in_ready, bsy: busy};
        $display("tx byte=%h we=%b addr=%h wdata=%h done=%b err=%b ready=%b busy=%b",
                 b, o.we, o.a, o.d, o.dn, o.er, o.rdy, o.bsy);
    endtask

    task automatic run_frame(input logic [7:0] bytes [$], output obs_t obs [$]);
        obs_t o;
        obs = {};
        foreach (bytes[i]) begin
            send(bytes[i], o);
            obs.push_back(o);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        checks++; if (last_count !== 9'd0) begin errors++; $display("FAIL reset_last_count: got %0d want 0", last_count); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle: busy=%b ready=%b want 0/1", busy, in_ready); end
        $display("tx reset released");
    endtask

    task automatic test_basic;
        logic [7:0] bytes [$];
        obs_t obs [$];
        bytes = {8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
        run_frame(bytes, obs);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i].we !== (i == 3 || i == 4)) begin errors++; $display("FAIL basic_we[%0d]: got %b want %b", i, obs[i].we, (i == 3 || i == 4)); end
        end
        checks++; if (obs[3].a !== 8'h10 || obs[3].d !== 8'h01) begin errors++; $display("FAIL basic_wr0: got %h/%h want 10/01", obs[3].a, obs[3].d); end
        checks++; if (obs[4].a !== 8'h11 || obs[4].d !== 8'h02) begin errors++; $display("FAIL basic_wr1: got %h/%h want 11/02", obs[4].a, obs[4].d); end
        checks++; if (obs[5].dn !== 1'b1 || obs[5].er !== 1'b0) begin errors++; $display("FAIL basic_done: done=%b err=%b want 1/0", obs[5].dn, obs[5].er); end
        checks++; if (obs[5].rdy !== 1'b0) begin errors++; $display("FAIL basic_report_ready: got %b want 0", obs[5].rdy); end
        checks++; if (obs[2].dn !== 1'b0 || obs[4].dn !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b/%b want 0/0", obs[2].dn, obs[4].dn); end
        checks++; if (last_count !== 9'd2) begin errors++; $display("FAIL basic_last_count: got %0d want 2", last_count); end
    endtask

    task automatic test_bad_csum;
        logic [7:0] bytes [$];
        obs_t obs [$];
        bytes = {8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEC};
        run_frame(bytes, obs);
        checks++; if (obs[3].we !== 1'b1 || obs[3].a !== 8'h10 || obs[3].d !== 8'h01) begin errors++; $display("FAIL bad_wr0: we=%b %h/%h want 1 10/01", obs[3].we, obs[3].a, obs[3].d); end
        checks++; if (obs[4].we !== 1'b1 || obs[4].a !== 8'h11 || obs[4].d !== 8'h02) begin errors++; $display("FAIL bad_wr1: we=%b %h/%h want 1 11/02", obs[4].we, obs[4].a, obs[4].d); end
        checks++; if (obs[5].dn !== 1'b0 || obs[5].er !== 1'b1) begin errors++; $display("FAIL bad_err: done=%b err=%b want 0/1", obs[5].dn, obs[5].er); end
        checks++; if (last_count !== 9'd2) begin errors++; $display("FAIL bad_last_count: got %0d want 2", last_count); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL bad_pulse_width: done=%b err=%b want 0/0", done, err); end
    endtask

    task automatic test_wrap;
        logic [7:0] bytes [$];
        obs_t obs [$];
        bytes = {8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h9A};
        run_frame(bytes, obs);
        checks++; if (obs[3].we !== 1'b1 || obs[3].a !== 8'hFF || obs[3].d !== 8'hAA) begin errors++; $display("FAIL wrap_wr0: we=%b %h/%h want 1 FF/AA", obs[3].we, obs[3].a, obs[3].d); end
        checks++; if (obs[4].we !== 1'b1 || obs[4].a !== 8'h00 || obs[4].d !== 8'hBB) begin errors++; $display("FAIL wrap_wr1: we=%b %h/%h want 1 00/BB", obs[4].we, obs[4].a, obs[4].d); end
        checks++; if (obs[5].dn !== 1'b1 || obs[5].er !== 1'b0) begin errors++; $display("FAIL wrap_done: done=%b err=%b want 1/0", obs[5].dn, obs[5].er); end
    endtask

    task automatic test_abort;
        logic [7:0] bytes [$];
        obs_t obs [$];
        bytes = {8'hA5, 8'h20, 8'h03, 8'h11};
        run_frame(bytes, obs);
        checks++; if (obs[3].we !== 1'b1 || obs[3].a !== 8'h20 || obs[3].d !== 8'h11) begin errors++; $display("FAIL abort_wr0: we=%b %h/%h want 1 20/11", obs[3].we, obs[3].a, obs[3].d); end
        in_data  = 8'h22;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        $display("tx abort with byte=22");
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_dropped: we=%b want 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abort_no_pulse: done=%b err=%b want 0/0", done, err); end
        checks++; if (last_count !== 9'd2) begin errors++; $display("FAIL abort_last_count: got %0d want 2", last_count); end
        bytes = {8'hA5, 8'h30, 8'h01, 8'h55, 8'h7A};
        run_frame(bytes, obs);
        checks++; if (obs[3].we !== 1'b1 || obs[3].a !== 8'h30 || obs[3].d !== 8'h55) begin errors++; $display("FAIL abort_next_wr: we=%b %h/%h want 1 30/55", obs[3].we, obs[3].a, obs[3].d); end
        checks++; if (obs[4].dn !== 1'b1 || obs[4].er !== 1'b0) begin errors++; $display("FAIL abort_next_done: done=%b err=%b want 1/0", obs[4].dn, obs[4].er); end
        checks++; if (last_count !== 9'd1) begin errors++; $display("FAIL abort_next_last_count: got %0d want 1", last_count); end
    endtask

    task automatic test_len_zero;
        logic [7:0] bytes [$];
        obs_t obs [$];
        int bad = 0;
        bytes = {8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) bytes.push_back(8'(i));
        bytes.push_back(8'h80);
        run_frame(bytes, obs);
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (obs[i+3].we !== 1'b1 || obs[i+3].a !== 8'(i) || obs[i+3].d !== 8'(i)) begin
                errors++;
                $display("FAIL len0_wr[%0d]: we=%b %h/%h want 1 %h/%h", i, obs[i+3].we, obs[i+3].a, obs[i+3].d, 8'(i), 8'(i));
            end
        end
        checks++; if (obs[259].we !== 1'b0) begin errors++; $display("FAIL len0_csum_no_write: we=%b want 0", obs[259].we); end
        checks++; if (obs[259].dn !== 1'b1 || obs[259].er !== 1'b0) begin errors++; $display("FAIL len0_done: done=%b err=%b want 1/0", obs[259].dn, obs[259].er); end
        checks++; if (last_count !== 9'd256) begin errors++; $display("FAIL len0_last_count: got %0d want 256", last_count); end
    endtask

    task automatic test_stall;
        logic [7:0] bytes [$];
        obs_t obs [$];
        bytes = {8'h33, 8'h44, 8'hA5, 8'h40, 8'h03, 8'h01};
        run_frame(bytes, obs);
        checks++; if (obs[0].we !== 1'b0 || obs[0].bsy !== 1'b0) begin errors++; $display("FAIL garbage0: we=%b busy=%b want 0/0", obs[0].we, obs[0].bsy); end
        checks++; if (obs[1].we !== 1'b0 || obs[1].bsy !== 1'b0) begin errors++; $display("FAIL garbage1: we=%b busy=%b want 0/0", obs[1].we, obs[1].bsy); end
        checks++; if (obs[2].bsy !== 1'b1) begin errors++; $display("FAIL stall_sync_busy: got %b want 1", obs[2].bsy); end
        checks++; if (obs[5].we !== 1'b1 || obs[5].a !== 8'h40 || obs[5].d !== 8'h01) begin errors++; $display("FAIL stall_wr0: we=%b %h/%h want 1 40/01", obs[5].we, obs[5].a, obs[5].d); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            $display("tx stall cycle %0d", i);
            checks++;
            if (mem_we !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: we=%b busy=%b ready=%b want 0/1/1", i, mem_we, busy, in_ready);
            end
        end
        bytes = {8'h02, 8'h03, 8'hB7};
        run_frame(bytes, obs);
        checks++; if (obs[0].we !== 1'b1 || obs[0].a !== 8'h41 || obs[0].d !== 8'h02) begin errors++; $display("FAIL stall_wr1: we=%b %h/%h want 1 41/02", obs[0].we, obs[0].a, obs[0].d); end
        checks++; if (obs[1].we !== 1'b1 || obs[1].a !== 8'h42 || obs[1].d !== 8'h03) begin errors++; $display("FAIL stall_wr2: we=%b %h/%h want 1 42/03", obs[1].we, obs[1].a, obs[1].d); end
        checks++; if (obs[0].rdy !== 1'b1 || obs[1].rdy !== 1'b1 || obs[2].rdy !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b%b%b want 110", obs[0].rdy, obs[1].rdy, obs[2].rdy); end
        checks++; if (obs[2].dn !== 1'b1 || obs[2].er !== 1'b0) begin errors++; $display("FAIL stall_done: done=%b err=%b want 1/0", obs[2].dn, obs[2].er); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_after_report: ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] bytes [$];
        obs_t obs [$];
        bytes = {8'hA5, 8'h50, 8'h02, 8'h77};
        run_frame(bytes, obs);
        checks++; if (obs[3].we !== 1'b1 || obs[3].a !== 8'h50 || obs[3].d !== 8'h77) begin errors++; $display("FAIL rstmid_wr0: we=%b %h/%h want 1 50/77", obs[3].we, obs[3].a, obs[3].d); end
        rst = 1'b0;
        #1;
        $display("tx async reset asserted mid-frame");
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin errors++; $display("FAIL rstmid_addr_data: got %h/%h want 00/00", mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: busy=%b ready=%b want 0/1", busy, in_ready); end
        checks++; if (last_count !== 9'd0) begin errors++; $display("FAIL rstmid_last_count: got %0d want 0", last_count); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bad_csum;
        test_wrap;
        test_abort;
        test_len_zero;
        test_stall;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
